prog_loader: RTL and testbench

// - Streams a program image into the core's instruction memory, holds the core in reset while loading,

---
 rtl/prog_loader_pkg.sv | 14 +
 rtl/prog_loader_byte_packer.sv | 73 +++++++
 rtl/prog_loader.sv | 153 +++++++++++++++
 tb/tb_prog_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHold,
    StRun,
    StDone
  } state_e;

  localparam logic [15:0] THUMB_NOP = 16'hBF00;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs an ascending byte stream into little-endian BPW-byte words, flushing a
// zero-padded partial word on the final byte; writes appear one cycle after the byte.
module prog_loader_byte_packer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BPW    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                push,
  input  logic                last,
  input  logic [7:0]          data,
  input  logic [ADDR_W:0]     byte_idx,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [8*BPW-1:0]    mem_wdata
);

  localparam logic [ADDR_W:0] BpwW    = (ADDR_W + 1)'(BPW);
  localparam logic [ADDR_W:0] LaneTop = (ADDR_W + 1)'(BPW - 1);

  logic [8*BPW-1:0] pack_q, pack_d, word, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   lane, base;
  logic              we_q, we_d;

  always_comb begin
    lane = byte_idx % BpwW;
    base = byte_idx - lane;
    // Upper lanes of pack_q are always zero, which gives the flush padding for free.
    word = pack_q;
    for (int i = 0; i < int'(BPW); i++) begin
      if (lane == (ADDR_W + 1)'(i)) word[8*i +: 8] = data;
    end
    pack_d  = pack_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (clear) begin
      pack_d  = '0;
      addr_d  = '0;
      wdata_d = '0;
    end else if (push) begin
      if (lane == LaneTop || last) begin
        we_d    = 1'b1;
        wdata_d = word;
        addr_d  = base[ADDR_W-1:0];
        pack_d  = '0;
      end else begin
        pack_d = word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      pack_q  <= pack_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: rtl/prog_loader.sv
// Loads a program image into instruction memory with the core held in reset, releases it,
// then watches the run until a repeated halt instruction or the cycle budget ends it.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BPW        = 2,
  parameter int unsigned RST_HOLD   = 4,
  parameter int unsigned MAX_CYCLES = 1024,
  parameter logic [15:0] HALT_INSTR = THUMB_NOP,
  parameter int unsigned HALT_RUN   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [8*BPW-1:0]  mem_wdata,
  output logic              cpu_rst,
  input  logic              fetch_valid,
  input  logic [15:0]       fetch_instr,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [ADDR_W:0]   byte_count
);

  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);
  localparam int unsigned CycW  = $clog2(MAX_CYCLES + 1);
  localparam int unsigned RunW  = $clog2(HALT_RUN + 1);
  localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic [RunW-1:0]   run_q, run_d;
  logic              done_q, done_d, timeout_q, timeout_d, overflow_q, overflow_d;
  logic              clear, push, halt, expire;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hold_d     = hold_q;
    cyc_d      = cyc_q;
    run_d      = run_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    clear      = 1'b0;
    push       = 1'b0;
    halt       = 1'b0;
    expire     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLoad;
          clear      = 1'b1;
          byte_cnt_d = '0;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          // Count saturates at full depth; excess bytes are drained but never written.
          if (byte_cnt_q == Depth) begin
            overflow_d = 1'b1;
          end else begin
            push       = 1'b1;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
          if (in_last) begin
            state_d = StHold;
            hold_d  = '0;
          end
        end
      end
      StHold: begin
        if (hold_q == HoldW'(RST_HOLD - 1)) begin
          state_d = StRun;
          cyc_d   = '0;
          run_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRun: begin
        cyc_d = cyc_q + 1'b1;
        if (fetch_valid) run_d = (fetch_instr == HALT_INSTR) ? run_q + 1'b1 : '0;
        halt   = (run_d == RunW'(HALT_RUN));
        expire = (cyc_q == CycW'(MAX_CYCLES - 1));
        if (halt || expire) begin
          state_d   = StDone;
          done_d    = 1'b1;
          timeout_d = !halt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      hold_q     <= '0;
      cyc_q      <= '0;
      run_q      <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hold_q     <= hold_d;
      cyc_q      <= cyc_d;
      run_q      <= run_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

  prog_loader_byte_packer #(
    .ADDR_W (ADDR_W),
    .BPW    (BPW)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .last      (in_last),
    .data      (in_data),
    .byte_idx  (byte_cnt_q),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  assign in_ready   = (state_q == StLoad);
  assign cpu_rst    = (state_q != StRun);
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Drives three loader configurations from one shared stimulus stream and checks
// writes, hold timing, halt/timeout outcomes, overflow and reset behaviour.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, fetch_valid;
  logic [7:0]  in_data;
  logic [15:0] fetch_instr;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // a: BPW=2, MAX_CYCLES=50; b: BPW=4; c: ADDR_W=4 (16-byte memory)
  logic        a_in_ready, a_mem_we, a_cpu_rst, a_done, a_timeout, a_overflow;
  logic [7:0]  a_mem_addr;
  logic [15:0] a_mem_wdata;
  logic [8:0]  a_byte_count;
  logic        b_in_ready, b_mem_we, b_cpu_rst, b_done, b_timeout, b_overflow;
  logic [7:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [8:0]  b_byte_count;
  logic        c_in_ready, c_mem_we, c_cpu_rst, c_done, c_timeout, c_overflow;
  logic [3:0]  c_mem_addr;
  logic [15:0] c_mem_wdata;
  logic [4:0]  c_byte_count;

  logic [7:0]  a_wa[$];
  logic [15:0] a_wd[$];
  int          a_wc[$];
  logic [7:0]  b_wa[$];
  logic [31:0] b_wd[$];
  logic [3:0]  c_wa[$];
  logic [15:0] c_wd[$];

  prog_loader #(.ADDR_W(8), .BPW(2), .RST_HOLD(4), .MAX_CYCLES(50), .HALT_RUN(3)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(a_in_ready), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .cpu_rst(a_cpu_rst), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .done(a_done), .timeout(a_timeout), .overflow(a_overflow),
    .byte_count(a_byte_count)
  );

  prog_loader #(.ADDR_W(8), .BPW(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(b_in_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .cpu_rst(b_cpu_rst), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .done(b_done), .timeout(b_timeout), .overflow(b_overflow),
    .byte_count(b_byte_count)
  );

  prog_loader #(.ADDR_W(4), .BPW(2)) u_dut_c (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(c_in_ready), .mem_we(c_mem_we), .mem_addr(c_mem_addr),
    .mem_wdata(c_mem_wdata), .cpu_rst(c_cpu_rst), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .done(c_done), .timeout(c_timeout), .overflow(c_overflow),
    .byte_count(c_byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_mem_we) begin
      a_wa.push_back(a_mem_addr);
      a_wd.push_back(a_mem_wdata);
      a_wc.push_back(cyc);
    end
    if (b_mem_we) begin
      b_wa.push_back(b_mem_addr);
      b_wd.push_back(b_mem_wdata);
    end
    if (c_mem_we) begin
      c_wa.push_back(c_mem_addr);
      c_wd.push_back(c_mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_logs();
    a_wa.delete(); a_wd.delete(); a_wc.delete();
    b_wa.delete(); b_wd.delete();
    c_wa.delete(); c_wd.delete();
  endtask

  // Bounded wait for core release on instance a; fall_cyc is the first RUN cycle.
  task automatic wait_release(input string tag, output int fall_cyc);
    for (int i = 0; i < 40 && a_cpu_rst; i++) step();
    fall_cyc = cyc;
    check(tag, {31'd0, a_cpu_rst}, 32'd0);
  endtask

  logic [7:0]  img1[6]  = '{8'hBF, 8'h00, 8'h20, 8'h3C, 8'h21, 8'h05};
  logic [15:0] fetch1[6] = '{16'hBF00, 16'hBF00, 16'h2001, 16'hBF00, 16'hBF00, 16'hBF00};

  initial begin
    int fall;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    fetch_valid = 1'b0; fetch_instr = '0;
    step(); step();
    rst = 1'b0;

    check("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, a_mem_we}, 32'd0);
    check("rst_mem_addr", {24'd0, a_mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, a_mem_wdata}, 32'd0);
    check("rst_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
    check("rst_done", {31'd0, a_done}, 32'd0);
    check("rst_timeout", {31'd0, a_timeout}, 32'd0);
    check("rst_overflow", {31'd0, a_overflow}, 32'd0);
    check("rst_byte_count", {23'd0, a_byte_count}, 32'd0);

    // Load BF 00 20 3C 21 05, then halt via NOP run
    pulse_start();
    check("load_in_ready", {31'd0, a_in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) send(img1[i], i == 5);
    wait_release("img1_release", fall);
    check("img1_a_nwr", a_wd.size(), 32'd3);
    if (a_wd.size() == 3) begin
      check("img1_a_w0", {8'd0, a_wa[0], a_wd[0]}, {8'd0, 8'd0, 16'h00BF});
      check("img1_a_w1", {8'd0, a_wa[1], a_wd[1]}, {8'd0, 8'd2, 16'h3C20});
      check("img1_a_w2", {8'd0, a_wa[2], a_wd[2]}, {8'd0, 8'd4, 16'h0521});
      check("img1_hold_len", fall - a_wc[2], 32'd4);
    end
    check("img1_byte_count", {23'd0, a_byte_count}, 32'd6);
    check("img1_b_nwr", b_wd.size(), 32'd2);
    if (b_wd.size() == 2) begin
      check("img1_b_w0", b_wd[0], 32'h3C2000BF);
      check("img1_b_w1", {24'd0, b_wa[1]} ^ b_wd[1], 32'h00000521 ^ 32'd4);
    end
    for (int i = 0; i < 6; i++) begin
      fetch_valid = 1'b1;
      fetch_instr = fetch1[i];
      if (i == 5) check("halt_early", {31'd0, a_done}, 32'd0);
      step();
    end
    fetch_valid = 1'b0;
    check("halt_done", {31'd0, a_done}, 32'd1);
    check("halt_timeout", {31'd0, a_timeout}, 32'd0);
    check("halt_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
    step(); step();
    check("halt_done_held", {31'd0, a_done}, 32'd1);

    // Load 01..05, then let instance a time out
    clear_logs();
    pulse_start();
    check("restart_done_clr", {31'd0, a_done}, 32'd0);
    for (int i = 0; i < 5; i++) send(8'(i + 1), i == 4);
    wait_release("img2_release", fall);
    check("img2_a_nwr", a_wd.size(), 32'd3);
    if (a_wd.size() == 3) check("img2_a_w2", {8'd0, a_wa[2], a_wd[2]}, {16'd4, 16'h0005});
    check("img2_b_nwr", b_wd.size(), 32'd2);
    if (b_wd.size() == 2) begin
      check("img2_b_w0", b_wd[0], 32'h04030201);
      check("img2_b_w1", b_wd[1], 32'h00000005);
      check("img2_b_a1", {24'd0, b_wa[1]}, 32'd4);
    end
    for (int k = 0; k < 50; k++) begin
      if (k == 49) check("to_early", {31'd0, a_done}, 32'd0);
      step();
    end
    check("to_done", {31'd0, a_done}, 32'd1);
    check("to_timeout", {31'd0, a_timeout}, 32'd1);
    check("to_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
    check("to_b_running", {31'd0, b_cpu_rst}, 32'd0);

    // Reset while b is mid-RUN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rrun_b_cpu_rst", {31'd0, b_cpu_rst}, 32'd1);
    check("rrun_b_byte_count", {23'd0, b_byte_count}, 32'd0);
    check("rrun_b_mem_addr", {24'd0, b_mem_addr}, 32'd0);
    check("rrun_b_mem_wdata", b_mem_wdata, 32'd0);
    check("rrun_a_timeout", {31'd0, a_timeout}, 32'd0);

    // 18-byte image: overflows the 16-byte instance c
    clear_logs();
    pulse_start();
    for (int i = 0; i < 18; i++) send(8'(i), i == 17);
    wait_release("img3_release", fall);
    check("ovf_c_released", {31'd0, c_cpu_rst}, 32'd0);
    check("ovf_c_nwr", c_wd.size(), 32'd8);
    if (c_wd.size() == 8) check("ovf_c_w7", {12'd0, c_wa[7], c_wd[7]}, {16'd14, 16'h0F0E});
    check("ovf_c_flag", {31'd0, c_overflow}, 32'd1);
    check("ovf_c_byte_count", {27'd0, c_byte_count}, 32'd16);
    check("ovf_a_flag", {31'd0, a_overflow}, 32'd0);
    check("ovf_a_byte_count", {23'd0, a_byte_count}, 32'd18);

    // Halt lands on the final budget cycle; start during RUN is ignored
    fetch_instr = 16'hBF00;
    for (int k = 0; k < 50; k++) begin
      fetch_valid = (k >= 47);
      start = (k == 5);
      if (k == 10) begin
        check("start_in_run_cpu", {31'd0, a_cpu_rst}, 32'd0);
        check("start_in_run_cnt", {23'd0, a_byte_count}, 32'd18);
      end
      if (k == 49) check("edge_early", {31'd0, a_done}, 32'd0);
      step();
    end
    start = 1'b0;
    fetch_valid = 1'b0;
    check("edge_done", {31'd0, a_done}, 32'd1);
    check("edge_timeout", {31'd0, a_timeout}, 32'd0);

    // Reset mid-LOAD
    pulse_start();
    for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 1'b0);
    check("rload_pre_count", {23'd0, a_byte_count}, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rload_in_ready", {31'd0, a_in_ready}, 32'd0);
    check("rload_byte_count", {23'd0, a_byte_count}, 32'd0);
    check("rload_mem_we", {31'd0, a_mem_we}, 32'd0);
    check("rload_mem_addr", {24'd0, a_mem_addr}, 32'd0);
    check("rload_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
    check("rload_done", {31'd0, a_done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
